iw_pingpong: RTL
================

// Module: iw_pingpong
// PURPOSE
//  Parametrised, double-buffered input wrapper between a word-serial upstream and the IMC.
//  Collects N_OPS operands of DATA_W bits one per handshake into a ping-pong bank pair,
//  then issues the full set to the IMC with a one-cycle imc_start pulse.
//  Filling the next set overlaps with IMC computation on the current set.
//  Adds a synchronous flush and status outputs.
// PARAMETERS
//  DATA_W  16  operand width in bits
//  N_OPS   4   operands per IMC job (>=2); slot 0 = first word accepted
// PORTS
//  clk         in   1             single clock, rising edge
//  rst         in   1             asynchronous, active-high reset
//  flush       in   1             sync: discard partial fill and pending banks
//  dataReady   in   1             upstream has a valid word on dataIn
//  dataIn      in   DATA_W        upstream word
//  dataAccept  out  1             block accepts dataIn this cycle
//  imc_ready   in   1             IMC idle, level
//  imc_start   out  1             one-cycle job start pulse (registered)
//  ops         out  N_OPS*DATA_W  operand set; slot k at [k*DATA_W +: DATA_W]
//  fill_idx    out  $clog2(N_OPS) next slot index in the fill bank
//  banks_full  out  2             complete sets awaiting issue (0..2)
// BEHAVIOUR
//  Interface: one clock (clk); reset rst is asynchronous and active-high.
//  Reset values: imc_start=0, ops=0, fill_idx=0, banks_full=0, wr_ptr=rd_ptr=0, issue FSM=IDLE.
//  dataAccept is combinational from registered state only: rst=0 && flush=0 && banks_full<2.
//  dataAccept never depends on dataReady.
//  Transfer occurs when dataReady && dataAccept at a rising edge: bank[wr_ptr][fill_idx] <= dataIn.
//  Transfer with fill_idx<N_OPS-1: fill_idx increments.
//  Transfer with fill_idx==N_OPS-1: fill_idx wraps to 0, wr_ptr toggles, banks_full increments.
//  Issue FSM:
//   - IDLE -> HOLD when banks_full>=1 && imc_ready. On that edge: imc_start<=1,
//     ops<=bank[rd_ptr], rd_ptr toggles, banks_full decrements.
//   - HOLD -> IDLE unconditionally after one cycle; imc_start<=0.
//     HOLD blocks back-to-back starts while the IMC drops imc_ready.
//  ops holds its value until the next issue; it stays valid for the whole IMC job.
//  Latency: last word accepted in cycle t; imc_start high in cycle t+2 if imc_ready is high.
//  Simultaneous completion and issue: banks_full is unchanged.
//  Completion writes bank[wr_ptr] while issue reads bank[rd_ptr]; these are always distinct.
//  Full: banks_full==2 forces dataAccept low. No same-cycle bypass.
//  dataAccept rises the cycle after an issue.
//  Empty: banks_full==0 means no issue, even with imc_ready high.
//  flush (priority over transfer and issue):
//   - clears fill_idx, banks_full, wr_ptr, rd_ptr and the FSM (to IDLE), and forces imc_start to 0.
//   - ops keeps its value; bank contents are don't-care.
//  Reset mid-operation: all state returns to reset values immediately.
//  While rst is high, dataAccept=0. No handshake completes during reset.
//  Bank width is exactly DATA_W. No arithmetic is done on data.
// STRUCTURE
//  Package iw_pkg: DATA_W_DEF, N_OPS_DEF, NUM_BANKS=2, typedef enum {IW_IDLE, IW_HOLD} iw_issue_t,
//  and a function idx_w(n) returning $clog2(n) (min 1).
//  Sub-module iw_bank: N_OPS x DATA_W register file with write enable/index and flat read port.
//  It is instantiated twice. Control (pointers, counters, FSM) lives in iw_pingpong.
// TESTING (DATA_W=16, N_OPS=4)
//  1. rst, then words 0x0001..0x0004 with imc_ready=1 ->
//     imc_start one cycle at t+2; ops = {0x0004,0x0003,0x0002,0x0001}.
//  2. imc_ready=0, stream 8 words ->
//     banks_full=2; dataAccept=0; 9th word held on dataIn.
//     Then imc_ready=1 -> issues first set; dataAccept=1 the next cycle.
//  3. imc_ready held 1 with two sets pending -> imc_start pulses separated by >=1 low cycle.
//     ops equals set 1, then set 2.
//  4. dataReady toggled randomly; imc_ready busy for 5 cycles per job ->
//     scoreboard shows every set delivered in order; no word lost or duplicated.
//  5. flush after 2 words of a set plus 1 pending set ->
//     fill_idx=0, banks_full=0, no imc_start; next 4 words form a correct new set.
//  6. rst asserted mid-fill and during imc_start ->
//     outputs at reset values immediately, dataAccept=0 while rst is high.

Source files
------------

// File: rtl/iw_pkg.sv
// Shared constants, issue-FSM state type and width helper for the ping-pong input wrapper.
package iw_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned N_OPS_DEF  = 4;
  localparam int unsigned NUM_BANKS  = 2;

  typedef enum logic [0:0] {
    IW_IDLE = 1'b0,
    IW_HOLD = 1'b1
  } iw_issue_t;

  // Index width for n entries, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/iw_pingpong_if.sv
// Upstream word handshake, IMC job interface and status bundle for iw_pingpong.
interface iw_pingpong_if
  import iw_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned N_OPS  = N_OPS_DEF
);

  localparam int unsigned IDX_W = idx_w(N_OPS);
  localparam int unsigned OPS_W = N_OPS * DATA_W;

  logic              flush;
  logic              dataReady;
  logic [DATA_W-1:0] dataIn;
  logic              dataAccept;
  logic              imc_ready;
  logic              imc_start;
  logic [OPS_W-1:0]  ops;
  logic [IDX_W-1:0]  fill_idx;
  logic [1:0]        banks_full;

  // Environment side: upstream producer plus IMC
  modport master (
    output flush, dataReady, dataIn, imc_ready,
    input  dataAccept, imc_start, ops, fill_idx, banks_full
  );

  // Wrapper side
  modport slave (
    input  flush, dataReady, dataIn, imc_ready,
    output dataAccept, imc_start, ops, fill_idx, banks_full
  );

endinterface

// File: rtl/iw_bank.sv
// One operand bank: N_OPS x DATA_W register file, single write port, flat read of all slots.
module iw_bank
  import iw_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned N_OPS  = N_OPS_DEF,
  localparam int unsigned IDX_W = idx_w(N_OPS),
  localparam int unsigned OPS_W = N_OPS * DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [DATA_W-1:0] wdata,
  output logic [OPS_W-1:0]  rdata
);

  logic [DATA_W-1:0] mem [N_OPS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(N_OPS); k++) begin
        mem[k] <= '0;
      end
    end else if (we) begin
      mem[widx] <= wdata;
    end
  end

  // Slot k lands at [k*DATA_W +: DATA_W]
  for (genvar k = 0; k < int'(N_OPS); k++) begin : g_rd
    assign rdata[k*DATA_W +: DATA_W] = mem[k];
  end

endmodule

// File: rtl/iw_pingpong.sv
// Double-buffered operand collector: fills one bank word by word while the other set is issued to the IMC.
module iw_pingpong
  import iw_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned N_OPS  = N_OPS_DEF
) (
  input  logic          clk,
  input  logic          rst,
  iw_pingpong_if.slave  bus
);

  localparam int unsigned IDX_W = idx_w(N_OPS);
  localparam int unsigned OPS_W = N_OPS * DATA_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OPS - 1);

  iw_issue_t        state_q;
  iw_issue_t        state_d;
  logic [IDX_W-1:0] fill_idx_q;
  logic [1:0]       banks_full_q;
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic             imc_start_q;
  logic [OPS_W-1:0] ops_q;

  logic             accept_c;
  logic             xfer_c;
  logic             complete_c;
  logic             issue_c;

  logic [OPS_W-1:0] bank_rd [NUM_BANKS];

  // Accept depends only on registered occupancy plus rst/flush, never on dataReady
  assign accept_c   = !rst && !bus.flush && (banks_full_q != 2'd2);
  assign xfer_c     = bus.dataReady && accept_c;
  assign complete_c = xfer_c && (fill_idx_q == LAST_IDX);

  for (genvar b = 0; b < int'(NUM_BANKS); b++) begin : g_bank
    iw_bank #(
      .DATA_W (DATA_W),
      .N_OPS  (N_OPS)
    ) u_bank (
      .clk   (clk),
      .rst   (rst),
      .we    (xfer_c && (wr_ptr_q == 1'(b))),
      .widx  (fill_idx_q),
      .wdata (bus.dataIn),
      .rdata (bank_rd[b])
    );
  end

  // Issue FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IW_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Issue FSM next state; HOLD spaces starts so the IMC can drop imc_ready
  always_comb begin
    state_d = state_q;
    issue_c = 1'b0;
    case (state_q)
      IW_IDLE: begin
        if ((banks_full_q != 2'd0) && bus.imc_ready) begin
          issue_c = 1'b1;
          state_d = IW_HOLD;
        end
      end
      IW_HOLD: state_d = IW_IDLE;
      default: state_d = IW_IDLE;
    endcase
    if (bus.flush) begin
      issue_c = 1'b0;
      state_d = IW_IDLE;
    end
  end

  // Fill/issue bookkeeping; flush leaves ops untouched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_idx_q   <= '0;
      banks_full_q <= 2'd0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      imc_start_q  <= 1'b0;
      ops_q        <= '0;
    end else if (bus.flush) begin
      fill_idx_q   <= '0;
      banks_full_q <= 2'd0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      imc_start_q  <= 1'b0;
    end else begin
      imc_start_q <= issue_c;
      if (xfer_c) begin
        fill_idx_q <= complete_c ? '0 : fill_idx_q + IDX_W'(1);
      end
      if (complete_c) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (issue_c) begin
        ops_q    <= bank_rd[rd_ptr_q];
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({complete_c, issue_c})
        2'b10:   banks_full_q <= banks_full_q + 2'd1;
        2'b01:   banks_full_q <= banks_full_q - 2'd1;
        default: banks_full_q <= banks_full_q;
      endcase
    end
  end

  assign bus.dataAccept = accept_c;
  assign bus.imc_start  = imc_start_q;
  assign bus.ops        = ops_q;
  assign bus.fill_idx   = fill_idx_q;
  assign bus.banks_full = banks_full_q;

endmodule
